// File: rtl/mux_pipeline_arbiter.sv
// mux_pipeline_arbiter: credit-throttled round-robin arbiter and skewed-select sequencer for a fixed-latency pipelined mux.
module mux_pipeline_arbiter #(
  parameter int INPUT_COUNT = 10,
  parameter int LEVEL_BITS  = 1,
  parameter int CREDITS     = 8,
  localparam int SEL_W  = $clog2(INPUT_COUNT),
  localparam int LEVELS = (SEL_W + LEVEL_BITS - 1) / LEVEL_BITS,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_COUNT-1:0] req,
  output logic [INPUT_COUNT-1:0] grant,
  output logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       out_id,
  input  logic                   credit_return,
  output logic [CW-1:0]          credit_count,
  output logic                   credit_err
);
  logic [SEL_W-1:0]       r_ptr;
  logic [SEL_W-1:0]       r_hist [LEVELS];
  logic [LEVELS-1:0]      r_vld;
  logic [CW-1:0]          r_cred;
  logic                   r_err;
  logic [INPUT_COUNT-1:0] w_elig;
  logic [SEL_W-1:0]       w_win;
  logic                   w_gnt;
  logic                   w_full;
  assign w_elig = (rst || r_cred == '0) ? '0 : req;
  assign w_gnt  = |w_elig;
  assign w_full = r_cred == CW'(CREDITS);
  // Winner is the eligible index with the smallest circular distance from r_ptr.
  always_comb begin
    int best;
    int d;
    w_win = '0;
    best  = INPUT_COUNT;
    d     = 0;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      d = (i >= int'(r_ptr)) ? i - int'(r_ptr) : i + INPUT_COUNT - int'(r_ptr);
      if (w_elig[i] && d < best) begin
        best  = d;
        w_win = SEL_W'(i);
      end
    end
  end
  assign grant = w_gnt ? (INPUT_COUNT'(1) << w_win) : '0;
  // Select bit b belongs to level b/LEVEL_BITS and comes from the grant that many cycles ago.
  always_comb begin
    sel = '0;
    for (int b = 0; b < SEL_W; b++)
      sel[b] = (b < LEVEL_BITS) ? w_win[b] : r_hist[(b / LEVEL_BITS == 0) ? 0 : b / LEVEL_BITS - 1][b];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_vld  <= '0;
      r_cred <= CW'(CREDITS);
      r_err  <= 1'b0;
      for (int i = 0; i < LEVELS; i++) r_hist[i] <= '0;
    end else begin
      if (w_gnt) r_ptr <= (int'(w_win) == INPUT_COUNT - 1) ? '0 : w_win + 1'b1;
      r_vld     <= LEVELS'({r_vld, w_gnt});
      r_hist[0] <= w_win;
      for (int i = 1; i < LEVELS; i++) r_hist[i] <= r_hist[i-1];
      if (credit_return && !w_gnt && w_full) r_err <= 1'b1;
      else r_cred <= r_cred - CW'(w_gnt) + CW'(credit_return);
    end
  end
  assign out_valid    = r_vld[LEVELS-1];
  assign out_id       = r_hist[LEVELS-1];
  assign credit_count = r_cred;
  assign credit_err   = r_err;
endmodule

// File: tb/tb_mux_pipeline_arbiter.sv
// tb_mux_pipeline_arbiter: directed scoreboard bench for the round-robin mux arbiter at default parameters.
module tb_mux_pipeline_arbiter;
  logic       clk = 0;
  logic       rst = 1;
  logic [9:0] req = '0;
  logic       credit_return = 0;
  logic [9:0] grant;
  logic [3:0] sel;
  logic       out_valid;
  logic [3:0] out_id;
  logic [3:0] credit_count;
  logic       credit_err;
  int vec = 0;
  int errs = 0;
  int m_ptr, m_cred, m_err;
  int h [4];
  int sb [$];
  always #5 clk = ~clk;
  mux_pipeline_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel),
    .out_valid(out_valid), .out_id(out_id), .credit_return(credit_return),
    .credit_count(credit_count), .credit_err(credit_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_ptr = 0; m_cred = 8; m_err = 0;
    for (int i = 0; i < 4; i++) h[i] = -1;
    sb.delete();
  endtask
  function automatic int pick(input logic [9:0] e);
    for (int k = 0; k < 10; k++)
      if (e[(m_ptr + k) % 10]) return (m_ptr + k) % 10;
    return -1;
  endfunction
  // Drive one cycle at the negedge, check everything mid-cycle, then advance the model at the posedge.
  task automatic tick(input logic [9:0] r, input logic cr);
    logic [9:0] e;
    logic [3:0] es;
    int w, id;
    req = r;
    credit_return = cr;
    #1;
    e = (m_cred == 0) ? 10'h0 : r;
    w = pick(e);
    es = '0;
    es[0] = (w < 0) ? 1'b0 : w[0];
    for (int g = 1; g < 4; g++) begin
      id = h[g-1];
      es[g] = (id < 0) ? 1'b0 : id[g];
    end
    chk("grant", 32'(grant), (w < 0) ? 32'd0 : 32'd1 << w);
    chk("sel", 32'(sel), 32'(es));
    chk("out_valid", 32'(out_valid), 32'(h[3] >= 0));
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) chk("out_id_unexpected", 32'(out_id), 32'hFFFF_FFFF);
      else chk("out_id", 32'(out_id), 32'(sb.pop_front()));
    end
    chk("credit_count", 32'(credit_count), 32'(m_cred));
    chk("credit_err", 32'(credit_err), 32'(m_err));
    @(posedge clk);
    if (w >= 0) begin
      m_ptr = (w + 1) % 10;
      sb.push_back(w);
    end
    for (int i = 3; i > 0; i--) h[i] = h[i-1];
    h[0] = w;
    if (cr && w < 0 && m_cred == 8) m_err = 1;
    else m_cred = m_cred - (w >= 0 ? 1 : 0) + (cr ? 1 : 0);
    @(negedge clk);
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(10'h0, h[3] >= 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_credit", 32'(credit_count), 8);
    chk("rst_err", 32'(credit_err), 0);
    rst = 0;
    tick(10'h004, 0);
    drain(6);
    for (int i = 0; i < 14; i++) tick(10'h3FF, h[3] >= 0);
    drain(6);
    tick(10'h100, 0);
    for (int i = 0; i < 3; i++) tick(10'h201, 0);
    drain(6);
    for (int i = 0; i < 10; i++) tick(10'h3FF, 0);
    tick(10'h3FF, 1);
    tick(10'h3FF, 0);
    tick(10'h3FF, 0);
    for (int i = 0; i < 8; i++) tick(10'h0, 1);
    drain(4);
    tick(10'h0, 1);
    tick(10'h0, 0);
    tick(10'h0, 0);
    for (int i = 0; i < 5; i++) tick(10'h3FF, 0);
    rst = 1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_credit", 32'(credit_count), 8);
    chk("midrst_err", 32'(credit_err), 0);
    chk("midrst_grant", 32'(grant), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    drain(6);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
